// File: rtl/mul4_pkg.sv
// Shared constants and FSM encoding for the 4x4 shift-add multiplier sequencer.
// Combinational only, no latency. No handshake, so no backpressure.
package mul4_pkg;

  localparam int MUL4_ITER  = 4;
  localparam int MUL4_W     = 4;
  localparam int MUL4_CNT_W = $clog2(MUL4_ITER);

  // Count value at which the current iteration is the final one.
  localparam logic [MUL4_CNT_W-1:0] MUL4_CNT_LAST = MUL4_CNT_W'(MUL4_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/four_bit_adder.sv
// Unsigned 4-bit ripple adder with carry-out; the multiplier's shared datapath.
// Purely combinational, zero cycles. No handshake, so no backpressure.
module four_bit_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] S_o,
  output logic       C_o
);

  assign {C_o, S_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-add multiplier driving one shared four_bit_adder.
// Accept edge to done_o is 4 cycles. start_i is dropped, not queued, while busy_o is high.
module mul4_seq
  import mul4_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [MUL4_W-1:0]     A_i,
  input  logic [MUL4_W-1:0]     B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2*MUL4_W-1:0]   P_o
);

  state_t state, state_nxt;

  logic [MUL4_W-1:0]     m;
  logic [MUL4_W-1:0]     acc;
  logic [MUL4_W-1:0]     q;
  logic [MUL4_CNT_W-1:0] cnt;

  logic [MUL4_W-1:0]     sum;
  logic                  carry;
  logic [2*MUL4_W-1:0]   shifted;
  logic                  load;
  logic                  step;
  logic                  last;

  four_bit_adder u_add (
    .a_i (acc),
    .b_i (m),
    .S_o (sum),
    .C_o (carry)
  );

  // Carry-out becomes the new MSB; when q[0] is clear the adder result is unused.
  assign shifted = q[0] ? {carry, sum, q[MUL4_W-1:1]}
                        : {1'b0, acc, q[MUL4_W-1:1]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == MUL4_CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m   <= '0;
      acc <= '0;
      q   <= '0;
      cnt <= '0;
      P_o <= '0;
    end else if (load) begin
      m   <= A_i;
      q   <= B_i;
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      {acc, q} <= shifted;
      cnt      <= cnt + 1'b1;
      if (last) P_o <= shifted;
    end
  end

  assign busy_o = (state == RUN);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_mul4_seq.sv
// Randomized self-checking bench for mul4_seq against a plain-arithmetic product model.
module tb_mul4_seq;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [3:0] A_i;
  logic [3:0] B_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] P_o;

  int checks = 0;
  int errors = 0;

  mul4_seq dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .A_i     (A_i),
    .B_i     (B_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .P_o     (P_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: operands scrambled after accept, 2: extra start pulse mid-run
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input int mode, input string tag);
    int busy_n;
    int lat;
    int extra;
    int exp_p;
    exp_p = int'(a) * int'(b);
    @(negedge clk_i);
    A_i = a; B_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    if (mode == 1) begin
      A_i = 4'($urandom); B_i = 4'($urandom);
    end
    busy_n = 0;
    lat    = -1;
    for (int n = 0; n < 12 && lat < 0; n++) begin
      if (busy_o) busy_n++;
      if (done_o) lat = n;
      if (mode == 2 && n == 1) begin
        start_i = 1'b1; A_i = 4'd2; B_i = 4'd3;
      end else if (mode == 2 && n == 2) begin
        start_i = 1'b0;
      end
      if (lat < 0) begin
        @(posedge clk_i); #1;
      end
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_busy_cycles"}, busy_n, 4);
    check({tag, "_product"}, {24'd0, P_o}, exp_p);
    @(posedge clk_i); #1;
    check({tag, "_done_width"}, {31'd0, done_o}, 0);
    check({tag, "_product_hold"}, {24'd0, P_o}, exp_p);
    if (mode == 2) begin
      extra = 0;
      for (int n = 0; n < 8; n++) begin
        @(posedge clk_i); #1;
        if (done_o) extra++;
      end
      check({tag, "_no_extra_done"}, extra, 0);
    end
  endtask

  initial begin
    logic [3:0] pa[3];
    logic [3:0] pb[3];
    int         dcyc[3];
    int         idx;
    int         cyc;
    int         seen;

    rst_i = 1'b1; start_i = 1'b0; A_i = '0; B_i = '0;
    #2;
    check("reset_busy", {31'd0, busy_o}, 0);
    check("reset_done", {31'd0, done_o}, 0);
    check("reset_p",    {24'd0, P_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    do_op(4'd0,  4'd0,  0, "zero");
    do_op(4'd15, 4'd15, 0, "max");
    do_op(4'd13, 4'd11, 0, "d13x11");
    do_op(4'd9,  4'd0,  0, "d9x0");

    for (int i = 0; i < 16; i++)
      do_op(4'($urandom_range(15)), 4'($urandom_range(15)), (i % 2), "rand");

    // Start held high, new pair presented in each DONE cycle.
    pa[0] = 4'd3;  pb[0] = 4'd5;
    pa[1] = 4'd7;  pb[1] = 4'd7;
    pa[2] = 4'd15; pb[2] = 4'd1;
    idx = 0; cyc = 0;
    @(negedge clk_i);
    A_i = pa[0]; B_i = pb[0]; start_i = 1'b1;
    for (int n = 0; n < 40 && idx < 3; n++) begin
      @(posedge clk_i); #1;
      cyc++;
      if (done_o) begin
        dcyc[idx] = cyc;
        check("b2b_product", {24'd0, P_o}, int'(pa[idx]) * int'(pb[idx]));
        idx++;
        if (idx < 3) begin
          A_i = pa[idx]; B_i = pb[idx];
        end else begin
          start_i = 1'b0;
        end
      end
    end
    check("b2b_count", idx, 3);
    if (idx == 3) begin
      check("b2b_gap1", dcyc[1] - dcyc[0], 5);
      check("b2b_gap2", dcyc[2] - dcyc[1], 5);
    end
    @(posedge clk_i); #1;

    do_op(4'd13, 4'd11, 2, "midrun");

    // Abort at iteration 2 with an asynchronous reset.
    @(negedge clk_i);
    A_i = 4'd6; B_i = 4'd7; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    #2 rst_i = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy_o}, 0);
    check("abort_done", {31'd0, done_o}, 0);
    check("abort_p",    {24'd0, P_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk_i); #1;
      if (done_o) seen++;
    end
    check("abort_no_done", seen, 0);
    do_op(4'd6, 4'd7, 0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
